// File: rtl/ring_osc_meter_pkg.sv
// Shared types and constants for ring-oscillator frequency measurement blocks.
package ring_osc_meter_pkg;

  // Measurement sequencer states (encoding appears in the status byte).
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_DONE   = 2'd3
  } meter_state_t;

  // Shortest gate window is 2**GATE_BASE_LOG2 clock cycles.
  localparam int GATE_BASE_LOG2 = 8;

  // Window counter width: holds W-1 for the longest window (2**23 cycles).
  localparam int WIN_W = 24;

  // Result byte select codes.
  localparam logic [1:0] RD_B0   = 2'd0;
  localparam logic [1:0] RD_B1   = 2'd1;
  localparam logic [1:0] RD_B2   = 2'd2;
  localparam logic [1:0] RD_STAT = 2'd3;

  // Terminal value of the window down-counter for a given gate select: W-1.
  function automatic logic [WIN_W-1:0] gate_last(input logic [3:0] sel);
    return (WIN_W'(1) << (GATE_BASE_LOG2 + int'(sel))) - WIN_W'(1);
  endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detector.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // s1/s2 resolve metastability; s3 holds the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Gated rising-edge counter measuring a ring-oscillator output against clk.
// Result and status are read byte-wise through rd_sel/rd_byte.
module ring_osc_freq_meter
  import ring_osc_meter_pkg::*;
#(
  parameter int CNT_W  = 24,
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       osc_in,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] gate_sel,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_byte,
  output logic       busy,
  output logic       valid,
  output logic       done,
  output logic       ovf
);

  localparam int SETTLE_W = $clog2(SETTLE);

  meter_state_t        r_state;
  meter_state_t        w_next;
  logic [3:0]          r_gsel;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [WIN_W-1:0]    r_win;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_acc;
  logic [CNT_W-1:0]    r_result;
  logic                r_ovf;
  logic                r_valid;
  logic                r_done;
  logic                w_rise;
  logic                w_busy;
  logic [CNT_W:0]      w_inc;
  logic [WIN_W-1:0]    w_res_ext;
  logic [1:0]          w_state_bits;

  // Saturating increment: returns {overflow_flag, count}; holds at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                             input logic ovf_in);
    if (&cnt) return {1'b1, cnt};
    return {ovf_in, cnt + CNT_W'(1)};
  endfunction

  osc_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (osc_in),
    .o_rise  (w_rise)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: settle flush, gate window, one-cycle result commit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == '0) w_next = S_GATE;
      S_GATE:   if (r_win == '0) w_next = S_DONE;
      S_DONE:   w_next = cont ? S_SETTLE : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_inc = sat_inc(r_cnt, r_ovf_acc);

  // Counters, latched gate select and result registers, sequenced by state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gsel       <= '0;
      r_settle_cnt <= '0;
      r_win        <= '0;
      r_cnt        <= '0;
      r_ovf_acc    <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_gsel       <= gate_sel;
            r_cnt        <= '0;
            r_ovf_acc    <= 1'b0;
            r_valid      <= 1'b0;
            r_settle_cnt <= SETTLE_W'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == '0) r_win <= gate_last(r_gsel);
          else                    r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
        end
        S_GATE: begin
          if (w_rise) begin
            r_ovf_acc <= w_inc[CNT_W];
            r_cnt     <= w_inc[CNT_W-1:0];
          end
          if (r_win != '0) r_win <= r_win - WIN_W'(1);
        end
        S_DONE: begin
          r_result <= r_cnt;
          r_ovf    <= r_ovf_acc;
          r_valid  <= 1'b1;
          r_done   <= 1'b1;
          if (cont) begin
            r_cnt        <= '0;
            r_ovf_acc    <= 1'b0;
            r_settle_cnt <= SETTLE_W'(SETTLE - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_busy       = (r_state == S_SETTLE) || (r_state == S_GATE);
  assign w_res_ext    = WIN_W'(r_result);
  assign w_state_bits = r_state;

  // Read mux: result bytes (zero above CNT_W) or the status byte.
  always_comb begin
    rd_byte = 8'h00;
    case (rd_sel)
      RD_B0:   rd_byte = w_res_ext[7:0];
      RD_B1:   rd_byte = w_res_ext[15:8];
      RD_B2:   rd_byte = w_res_ext[23:16];
      RD_STAT: rd_byte = {r_ovf, w_busy, r_valid, cont, w_state_bits, 2'b00};
      default: rd_byte = 8'h00;
    endcase
  end

  assign busy  = w_busy;
  assign valid = r_valid;
  assign done  = r_done;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done.
module tb_ring_osc_freq_meter;
  import ring_osc_meter_pkg::*;

  localparam int SET = 4;
  localparam int P0  = SET + 257;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       osc = 1'b0;
  logic       start24 = 1'b0;
  logic       start8 = 1'b0;
  logic       cont = 1'b0;
  logic       cont8 = 1'b0;
  logic [3:0] gate_sel = 4'd0;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] rb24, rb8;
  logic       busy24, valid24, done24, ovf24;
  logic       busy8, valid8, done8, ovf8;

  ring_osc_freq_meter #(.CNT_W(24), .SETTLE(SET)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start24), .cont(cont),
    .gate_sel(gate_sel), .rd_sel(rd_sel), .rd_byte(rb24), .busy(busy24),
    .valid(valid24), .done(done24), .ovf(ovf24)
  );

  ring_osc_freq_meter #(.CNT_W(8), .SETTLE(SET)) dut8 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start8), .cont(cont8),
    .gate_sel(gate_sel), .rd_sel(rd_sel), .rd_byte(rb8), .busy(busy8),
    .valid(valid8), .done(done8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: osc_half=0 holds osc_hold, else square wave of period 2*osc_half clocks.
  int   osc_half = 0;
  logic osc_hold = 1'b0;
  initial forever begin
    @(negedge clk);
    if (osc_half == 0) osc = osc_hold;
    else               osc = ((cyc / osc_half) % 2) == 1;
  end

  typedef struct {
    int cyc;
    int lo;
    int hi;
    bit ovf;
  } exp_t;

  exp_t q24[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic read_all(input bit which, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      v[8*i +: 8] = which ? rb8 : rb24;
    end
  endtask

  task automatic check_out(input bit which);
    exp_t e;
    logic [31:0] v;
    int res;
    if ((which && q8.size() == 0) || (!which && q24.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d at cycle %0d", which ? 8 : 24, cyc);
      return;
    end
    e = which ? q8.pop_front() : q24.pop_front();
    chk("done_cycle", cyc, e.cyc);
    read_all(which, v);
    res = int'(v[23:0]);
    checks++;
    if (res < e.lo || res > e.hi) begin
      errors++;
      $display("FAIL result: got %0d expected %0d..%0d", res, e.lo, e.hi);
    end
    chk("ovf_port", int'(which ? ovf8 : ovf24), int'(e.ovf));
    chk("valid_port", int'(which ? valid8 : valid24), 1);
    chk("status_bits", int'(v[31:24] & 8'hA3), e.ovf ? 32'hA0 : 32'h20);
  endtask

  // Monitor: every done pulse is matched against the head of its queue.
  initial forever begin
    @(negedge clk);
    if (done24 === 1'b1) check_out(1'b0);
    if (done8 === 1'b1)  check_out(1'b1);
  end

  task automatic start_meas(input bit which, input int gsel, input int lo,
                            input int hi, input bit ov, input bit push);
    exp_t e;
    int k;
    @(negedge clk);
    gate_sel = 4'(gsel);
    if (which) start8 = 1'b1; else start24 = 1'b1;
    k = cyc + 1;
    e.cyc = k + SET + (256 << gsel) + 1;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ov;
    if (push) begin
      if (which) q8.push_back(e); else q24.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start24 = 1'b0;
    chk("busy_after_start", int'(which ? busy8 : busy24), 1);
  endtask

  task automatic wait_q(input int n, input int budget);
    int t;
    t = 0;
    while ((q24.size() + q8.size()) > n && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if ((q24.size() + q8.size()) > n) begin
      errors++;
      $display("FAIL wait_done_timeout: pending %0d expected %0d", q24.size() + q8.size(), n);
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_busy", int'(busy24), 0);
    chk("rst_valid", int'(valid24), 0);
    chk("rst_ovf", int'(ovf24), 0);
    chk("rst_done", int'(done24), 0);
    chk("rst_valid8", int'(valid8), 0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rst_byte24", int'(rb24), 0);
      chk("rst_byte8", int'(rb8), 0);
    end
  endtask

  initial begin
    int drops;
    int d;
    exp_t e;

    // Power-on reset
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // clk/4 wave, 256-cycle window: 64 edges
    osc_half = 2;
    start_meas(1'b0, 0, 63, 65, 1'b0, 1'b1);
    wait_q(0, 2000);

    // Constant input, held low then high: no edges
    osc_half = 0;
    osc_hold = 1'b0;
    start_meas(1'b0, 2, 0, 0, 1'b0, 1'b1);
    wait_q(0, 3000);
    osc_hold = 1'b1;
    repeat (5) @(negedge clk);
    start_meas(1'b0, 2, 0, 0, 1'b0, 1'b1);
    wait_q(0, 3000);

    // 8-bit counter, clk/2 wave, 512 cycles: 256 edges saturate at 255
    osc_half = 1;
    start_meas(1'b1, 1, 255, 255, 1'b1, 1'b1);
    wait_q(0, 3000);

    // start re-pulsed and gate_sel changed mid-window are ignored
    osc_half = 2;
    start_meas(1'b0, 0, 63, 65, 1'b0, 1'b1);
    drops = 0;
    for (int i = 1; i < SET + 256; i++) begin
      @(negedge clk);
      if (!busy24) drops++;
      if (i == SET + 50) begin
        gate_sel = 4'd3;
        start24  = 1'b1;
      end
      if (i == SET + 52) start24 = 1'b0;
    end
    chk("busy_continuous", drops, 0);
    wait_q(0, 2000);
    repeat (300) @(negedge clk);
    rd_sel = RD_STAT;
    #1;
    chk("idle_after_ignored_start", int'(rb24[3:2]), 0);

    // Continuous mode, clk/8 wave: results every SETTLE+257 cycles
    osc_half = 4;
    cont = 1'b1;
    start_meas(1'b0, 0, 31, 33, 1'b0, 1'b1);
    d = q24[0].cyc;
    e.lo = 31;
    e.hi = 33;
    e.ovf = 1'b0;
    e.cyc = d + P0;
    q24.push_back(e);
    e.cyc = d + 2 * P0;
    q24.push_back(e);
    wait_q(1, 3 * P0);
    repeat (100) @(negedge clk);
    cont = 1'b0;
    wait_q(0, 2 * P0);
    repeat (P0 + 50) @(negedge clk);
    chk("cont_drop_busy", int'(busy24), 0);
    rd_sel = RD_STAT;
    #1;
    chk("cont_drop_idle", int'(rb24[3:2]), 0);

    // Reset mid-window aborts and clears everything
    osc_half = 2;
    start_meas(1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (SET + 100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    start_meas(1'b0, 0, 63, 65, 1'b0, 1'b1);
    wait_q(0, 2000);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ring_osc_freq_meter.md
# ring_osc_freq_meter

Gated edge counter that measures the frequency of a selected ring-oscillator output (`en`/`y` of the ring_osc_part_* instances) against the system clock. The oscillator output feeds this block asynchronously. The block synchronizes it and counts rising edges over a programmable window of clock cycles. The result is presented byte-wise so it fits the 8-bit project output bus.

## Interface
Parameters:
- `CNT_W`, 24: edge-count/result width. Legal range 8..24.
- `SETTLE`, 4: number of synchronizer flush cycles before the gate opens. Minimum 3.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `osc_in`  in  1  ring-oscillator output, asynchronous to `clk`.
- `start`  in  1  level-sampled measurement request.
- `cont`  in  1  continuous mode: re-arm automatically after each result.
- `gate_sel`  in  4  gate window W = 256 << gate_sel clock cycles (256..8,388,608).
- `rd_sel`  in  2  result byte select.
- `rd_byte`  out  8  selected result/status byte.
- `busy`  out  1  high in SETTLE or GATE.
- `valid`  out  1  result register holds a completed measurement.
- `done`  out  1  one-cycle pulse when the result updates.
- `ovf`  out  1  the last measurement saturated.

## Operation
- Synchronizer: `osc_in` goes through 2 flops (s1, s2) plus a history flop s3. `edge` = s2 & ~s3.
- FSM states: IDLE, SETTLE, GATE, DONE.
  - IDLE: when `start`=1, latch `gate_sel`, clear the edge counter and `ovf_acc`, clear `valid`, and go to SETTLE.
  - SETTLE: stays for `SETTLE` cycles. Edges are ignored. Then the window counter loads W-1 and the state goes to GATE.
  - GATE: every cycle with `edge`=1 increments the edge counter. At all-ones the counter holds and `ovf_acc` is set. The window counter decrements. The cycle in which it reads 0 is the last GATE cycle (an edge in that cycle is counted). Then the state goes to DONE.
  - DONE: one cycle. Result <= edge counter, `ovf` <= `ovf_acc`, `valid` <= 1, `done` = 1. Next state is SETTLE (with counters cleared) if `cont`=1, else IDLE.
- `start` in any state other than IDLE is ignored. Changes to `gate_sel` after acceptance do not affect the measurement in progress.
- In continuous mode, `valid` stays high and the result is overwritten at each DONE. Consecutive windows are separated by SETTLE+1 cycles.
- Dropping `cont` mid-measurement lets the current measurement finish, then the FSM returns to IDLE.
- `rd_byte` (combinational from registers):
  - `rd_sel` 0/1/2: result bits [7:0]/[15:8]/[23:16]. Bits at or above `CNT_W` read 0.
  - `rd_sel` 3: {`ovf`, `busy`, `valid`, `cont`, state[1:0], 2'b00}.
- Measurable range: osc frequency < clk/2. Faster inputs alias; this is a documented limitation and is not detected.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE. Synchronizer flops, counters, result, `valid`, `ovf`, `done` and `busy` all 0. So `rd_byte`=0 for every `rd_sel`.
- Reset mid-GATE aborts the measurement. The old result is lost and `valid`=0.
- Latency: `start` sampled at edge k → `busy`=1 from k+1. GATE spans W cycles. `done`/`valid` rise exactly k+1+SETTLE+W cycles after k, i.e. `SETTLE`+W+1 cycles after the start edge.
- Edge-to-count latency: 3 clk cycles (s1, s2, s3). Edges reaching s2 during SETTLE are discarded.
- `busy` is low in IDLE and DONE.

## Structure
- Shared package `ring_osc_meter_pkg`:
  - state enum `meter_state_t` {IDLE, SETTLE, GATE, DONE};
  - constant `GATE_BASE_LOG2 = 8`;
  - `rd_sel` codes `RD_B0`, `RD_B1`, `RD_B2`, `RD_STAT`.
- One sub-module: `osc_sync_edge` (2-flop synchronizer plus rising-edge detector, synchronous active-low reset). It is reusable by other measurement blocks.

## Test plan
- Square wave at clk/4 on `osc_in`, `gate_sel`=0, `start` pulse → `done` after SETTLE+257 cycles. Result 64 (±1 for phase). `ovf`=0. `rd_byte` with `rd_sel`=0 gives 0x40; with 1 and 2 gives 0x00.
- `osc_in` held 0 (then held 1), `gate_sel`=2 → result 0, `valid`=1, `ovf`=0.
- `CNT_W`=8, clk/2 square wave, `gate_sel`=1 (512 cycles, 256 edges) → result 255, `ovf`=1, status byte bit7=1.
- `start` re-pulsed and `gate_sel` changed during GATE → ignored. The single result matches the original window. `busy` stays continuous.
- `cont`=1, clk/8 wave, `gate_sel`=0 → `done` pulses every SETTLE+257 cycles. Each result is 32 (±1). Drop `cont` → exactly one more `done`, then IDLE.
- `rst_n`=0 for 1 cycle mid-GATE → next cycle state IDLE, `busy`=0, `valid`=0, all bytes 0. A new `start` measures correctly.
